// File: rtl/seconds_bcd_pkg.sv
// Shared definitions for the seconds-to-BCD receiver.
//   state_e      : receiver FSM states (2-bit encoding, value 3 is unused)
//   ITERATIONS   : double-dabble shift count for a 16-bit value
//   ACC_DIGITS   : width of the internal BCD accumulator in digits
//   SAT_VALUE_4  : display value used when a 4-digit build saturates
package seconds_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_e;

  localparam int ITERATIONS = 16;
  localparam int ACC_DIGITS = 5;
  localparam logic [15:0] SAT_VALUE_4 = 16'h9999;

endpackage

// File: rtl/seconds_bcd_rx_if.sv
// Bus bundle for the seconds-to-BCD receiver.
//   Upstream channel  : input_seconds, input_seconds_stb (to receiver), input_seconds_ack (from receiver)
//   Downstream channel: output_bcd, output_bcd_overflow, output_bcd_stb (from receiver), output_bcd_ack (to receiver)
//   dbg_state         : current receiver FSM state, observation only
//
// Handshake (both channels): a word moves on a rising clock edge where stb
// and ack are both 1. The sender raises stb with its data and keeps data
// stable until that edge; ack may be asserted independently of stb.
//
// Modports: slave = the receiver block, master = whatever feeds and drains it.
interface seconds_bcd_rx_if #(
  parameter int DIGITS = 5
) ();
  import seconds_bcd_pkg::*;

  logic [15:0]         input_seconds;
  logic                input_seconds_stb;
  logic                input_seconds_ack;
  logic [4*DIGITS-1:0] output_bcd;
  logic                output_bcd_overflow;
  logic                output_bcd_stb;
  logic                output_bcd_ack;
  state_e              dbg_state;

  modport slave (
    input  input_seconds,
    input  input_seconds_stb,
    output input_seconds_ack,
    output output_bcd,
    output output_bcd_overflow,
    output output_bcd_stb,
    input  output_bcd_ack,
    output dbg_state
  );

  modport master (
    output input_seconds,
    output input_seconds_stb,
    input  input_seconds_ack,
    input  output_bcd,
    input  output_bcd_overflow,
    input  output_bcd_stb,
    output output_bcd_ack,
    input  dbg_state
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next digit.
//   digit_i : BCD digit before correction (0..9)
//   digit_o : corrected digit
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/seconds_bcd_rx.sv
// Seconds-to-BCD receiver. Accepts a 16-bit unsigned value over the upstream
// stb/ack channel, converts it with a serial double-dabble (one shift per
// clock, 16 shifts) and offers the packed BCD result downstream.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : seconds_bcd_rx_if.slave (both handshake channels plus dbg_state)
// Parameters:
//   DIGITS : output digits, 4 or 5; with 4, values above 9999 saturate to 9999
//   WIDTH  : input width, always 16
module seconds_bcd_rx
  import seconds_bcd_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  seconds_bcd_rx_if.slave bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ACC_W  = 4 * ACC_DIGITS;
  localparam int TOP_LO = 4 * (ACC_DIGITS - 1);
  localparam int CNT_W  = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               ack_q, ack_d;
  logic               stb_q, stb_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.input_seconds_stb & ack_q;
  assign out_xfer = stb_q & bus.output_bcd_ack;

  // One correction cell per accumulator digit.
  for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Encoding 2'b11 falls into default and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_xfer)             state_d = CONVERT;
      CONVERT: if (cnt_q == LAST_CNT)   state_d = SEND;
      SEND:    if (out_xfer)            state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    cnt_d = cnt_q;
    bin_d = bin_q;
    acc_d = acc_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    ack_d = ack_q;
    stb_d = stb_q;
    case (state_q)
      IDLE: begin
        ack_d = 1'b1;
        if (in_xfer) begin
          bin_d = bus.input_seconds;
          acc_d = '0;
          cnt_d = '0;
          ack_d = 1'b0;
        end
      end
      CONVERT: begin
        ack_d = 1'b0;
        {acc_d, bin_d} = {acc_adj, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Result is loaded on the final shift; stb follows one clock later
        // so output_bcd is already settled when the strobe rises.
        if (cnt_q == LAST_CNT) begin
          if ((DIGITS == 4) && (acc_d[ACC_W-1:TOP_LO] != 4'd0)) begin
            bcd_d = BCD_W'(SAT_VALUE_4);
            ovf_d = 1'b1;
          end else begin
            bcd_d = acc_d[BCD_W-1:0];
            ovf_d = 1'b0;
          end
        end
      end
      SEND: begin
        ack_d = 1'b0;
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (bus.output_bcd_ack) begin
          stb_d = 1'b0;
          ack_d = 1'b1;
        end
      end
      default: begin
        ack_d = 1'b0;
        stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      bin_q <= '0;
      acc_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      ack_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      acc_q <= acc_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      ack_q <= ack_d;
      stb_q <= stb_d;
    end
  end

  assign bus.input_seconds_ack   = ack_q;
  assign bus.output_bcd          = bcd_q;
  assign bus.output_bcd_overflow = ovf_q;
  assign bus.output_bcd_stb      = stb_q;
  assign bus.dbg_state           = state_q;

endmodule

// File: doc/seconds_bcd_rx.md
Name: seconds_bcd_rx

Overview:
- Receiving end of the 16-bit seconds stream produced by the speedometer's seconds counter.
- Accepts each value over the stb/ack handshake and converts it to packed BCD with a serial double-dabble: one shift per clock, 16 iterations.
- Presents the digits to the display driver over a second stb/ack handshake of the same protocol.
- Holds off the upstream sender while a conversion or an output transfer is in progress.

Parameters:
- DIGITS, 5, number of BCD digits output (legal values 4 or 5). With 4, values above 9999 saturate.
- WIDTH, 16, input value width. Fixed at 16; present for documentation and checking only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- input_seconds  input  16  unsigned value from the sender.
- input_seconds_stb  input  1  sender data valid.
- input_seconds_ack  output  1  receiver ready/accept.
- output_bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- output_bcd_overflow  output  1  value saturated (DIGITS=4 only); valid with output_bcd.
- output_bcd_stb  output  1  BCD data valid.
- output_bcd_ack  input  1  display accepts.

Behaviour:
- Handshake rule, both ports: a transfer occurs on a rising edge where stb and ack are both 1. Sender holds data stable while stb=1. All outputs are registered.
- Reset (rst=0, asynchronous) forces:
  - state=IDLE
  - input_seconds_ack=0, output_bcd_stb=0
  - output_bcd=0, output_bcd_overflow=0
  - shift register and iteration counter = 0.
- First clock after reset release: ack rises to 1.
- IDLE: input_seconds_ack=1.
  - On an edge with input_seconds_stb=1 and ack=1: capture input_seconds into the binary shift register, clear the BCD accumulator, set count=0, ack<=0, go to CONVERT.
  - ack is never 1 outside IDLE.
- CONVERT (16 cycles): each cycle
  - every BCD digit >=5 first gets +3;
  - then {bcd, bin} shifts left by 1;
  - count increments.
  - After the 16th shift (count=15 edge), go to SEND and load output_bcd and overflow.
  - Saturation (DIGITS=4): if the internal 5th digit is nonzero, output_bcd=0x9999 and overflow=1; otherwise overflow=0.
  - The internal accumulator is always 5 digits (20 bits), so 65535 never overflows it.
- SEND: output_bcd_stb=1; output_bcd and overflow stable.
  - On an edge with stb=1 and output_bcd_ack=1: stb<=0, ack<=1, go to IDLE.
  - output_bcd retains its last value after the transfer.
- Latency, input transfer edge to output_bcd_stb=1: 17 clocks (16 convert + 1 load).
- Minimum interval between successive input accepts: 19 clocks with output_bcd_ack tied high.
- Backpressure: if output_bcd_ack stays 0, remain in SEND indefinitely with ack=0. Upstream stalls and no values are lost or overwritten.
- input_seconds_stb high in CONVERT/SEND: ignored, no capture.
- output_bcd_ack high outside SEND: ignored.
- Reset mid-CONVERT or mid-SEND: abort immediately to reset values. The partial result is discarded and never presented.
- Illegal state encoding: recover to IDLE.

Decomposition:
- Package seconds_bcd_pkg holds:
  - state enum IDLE/CONVERT/SEND (2-bit);
  - constant ITERATIONS=16 and ACC_DIGITS=5;
  - constant SAT_VALUE_4=16'h9999.
- Sub-module bcd_add3: combinational 4-bit digit correction (d>=5 ? d+3 : d), instantiated once per accumulator digit (5×).
- FSM, counter and shift register stay in the top module.

Test Plan:
- DIGITS=5, send 0 → output_bcd=20'h00000, overflow=0; stb rises exactly 17 clocks after the input transfer edge.
- DIGITS=5, send 65535 then 12345 back to back with output ack tied high → 20'h65535, then 20'h12345. Second input ack is 0 for 18 clocks after the first accept.
- DIGITS=4, send 9999 → 16'h9999 with overflow=0; send 10000 → 16'h9999 with overflow=1; send 1000 → 16'h1000 with overflow=0.
- Backpressure: send 59, hold output_bcd_ack=0 for 50 clocks while the sender offers 60 → stb and 20'h00059 held, input ack=0 throughout. Release ack → 59 transferred, then 60 accepted and produces 20'h00060.
- Reset pulse (rst=0 for 1 cycle) at convert cycle 8 of value 1000 → all outputs 0 asynchronously; no stb for 1000. The next value sent, 7, yields 20'h00007.
- Random 500 values with random stb/ack gaps vs a reference decimal model → every value delivered exactly once, in order, correct BCD.
